// File: rtl/clock_reset_supervisor.sv
// Clock/reset supervisor: pulses PLL/DCM resets, qualifies lock stability, releases
// domain resets in index order, re-sequences on loss of lock and latches a fault after repeated timeouts.
module clock_reset_supervisor #(
    parameter int N_PLL         = 2,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int SEQ_GAP       = 8,
    parameter int MAX_RETRY     = 7,
    parameter int CNT_W         = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_PLL-1:0] lock_in,
    input  logic             force_reset,
    output logic [N_PLL-1:0] pll_rst,
    output logic [N_PLL-1:0] domain_rst,
    output logic             all_ready,
    output logic             fault,
    output logic [3:0]       retry_count,
    output logic [7:0]       lol_count,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(SEQ_GAP - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);
    localparam logic [N_PLL-1:0] ALL_ONES     = '1;

    logic [N_PLL-1:0] sync1_q, sync2_q;
    logic             lk;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N_PLL-1:0] pll_rst_q;
    logic [N_PLL-1:0] domain_rst_q;
    logic             all_ready_q;
    logic             fault_q;
    logic [3:0]       retry_q;
    logic [7:0]       lol_q;
    logic [3:0]       retry_inc;

    // NOTE: non-blocking assignments make sync2_q sample the old sync1_q, giving two real flop stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= lock_in;
            sync2_q <= sync1_q;
        end
    end

    assign lk        = &sync2_q;
    assign retry_inc = retry_q + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_RESET_PLL;
            cnt_q        <= '0;
            pll_rst_q    <= '1;
            domain_rst_q <= '1;
            all_ready_q  <= 1'b0;
            fault_q      <= 1'b0;
            retry_q      <= '0;
            lol_q        <= '0;
        end else if (force_reset) begin
            state_q      <= S_RESET_PLL;
            cnt_q        <= '0;
            pll_rst_q    <= '1;
            domain_rst_q <= '1;
            all_ready_q  <= 1'b0;
            fault_q      <= 1'b0;
            retry_q      <= '0;
        end else begin
            case (state_q)
                S_RESET_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_q   <= S_WAIT_LOCK;
                        cnt_q     <= '0;
                        pll_rst_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (lk) begin
                        state_q <= S_STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_q <= retry_inc;
                        cnt_q   <= '0;
                        if (retry_inc == RETRY_LIMIT) begin
                            state_q      <= S_FAULT;
                            fault_q      <= 1'b1;
                            domain_rst_q <= '1;
                        end else begin
                            state_q   <= S_RESET_PLL;
                            pll_rst_q <= '1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_STABLE: begin
                    if (!lk) begin
                        state_q <= S_WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_q      <= S_RELEASE;
                        cnt_q        <= '0;
                        domain_rst_q <= ALL_ONES << 1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    // Releases walk a zero up from bit 0; the top bit clearing marks the sequence done.
                    if (!lk) begin
                        state_q      <= S_RESET_PLL;
                        cnt_q        <= '0;
                        pll_rst_q    <= '1;
                        domain_rst_q <= '1;
                    end else if (!domain_rst_q[N_PLL-1]) begin
                        state_q     <= S_RUN;
                        cnt_q       <= '0;
                        all_ready_q <= 1'b1;
                    end else if (cnt_q == GAP_LAST) begin
                        cnt_q        <= '0;
                        domain_rst_q <= domain_rst_q << 1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (!lk) begin
                        state_q      <= S_RESET_PLL;
                        cnt_q        <= '0;
                        pll_rst_q    <= '1;
                        domain_rst_q <= '1;
                        all_ready_q  <= 1'b0;
                        retry_q      <= '0;
                        if (lol_q != 8'hFF) lol_q <= lol_q + 8'd1;
                    end
                end
                S_FAULT: begin
                    pll_rst_q    <= '0;
                    domain_rst_q <= '1;
                    fault_q      <= 1'b1;
                end
                default: begin
                    state_q      <= S_RESET_PLL;
                    cnt_q        <= '0;
                    pll_rst_q    <= '1;
                    domain_rst_q <= '1;
                    all_ready_q  <= 1'b0;
                    fault_q      <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst     = pll_rst_q;
    assign domain_rst  = domain_rst_q;
    assign all_ready   = all_ready_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;
    assign lol_count   = lol_q;
    assign state_dbg   = state_q;

endmodule
